// File: rtl/trdb_udma_fifo.sv
// rtl/trdb_udma_fifo.sv - trace word FIFO to uDMA with overflow accounting and watermark irq
// Optional feature: define TRDB_OVERFLOW_MARKER_EN to insert a {16'hDEAD, drop count} marker word
// after an overflow episode, ahead of any new trace word.
module trdb_udma_fifo #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNTW  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     enable_i,
    input  logic                     flush_i,
    input  logic [XLEN-1:0]          word_i,
    input  logic                     word_valid_i,
    input  logic [$clog2(DEPTH):0]   threshold_i,
    output logic [XLEN-1:0]          udma_data_o,
    output logic                     udma_valid_o,
    input  logic                     udma_ready_i,
    output logic [$clog2(DEPTH):0]   fill_level_o,
    output logic                     overflow_o,
    output logic [CNTW-1:0]          dropped_cnt_o,
    output logic                     threshold_irq_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = AW + 1;

    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        DROPPING = 2'd1,
        MARKER   = 2'd2
    } state_e;

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [FW-1:0]   count_q, count_d, prev_count_q;
    logic            overflow_q;
    logic [CNTW-1:0] dropped_q;
    logic            irq_q;
    state_e          state_q;

    logic            full, not_empty, pop, trace_req, trace_allowed;
    logic            trace_push, marker_push, push, drop;
    logic [XLEN-1:0] push_data;

`ifdef TRDB_OVERFLOW_MARKER_EN
    // Marker word: drop count zero-extended/truncated to 16 bits, whole word fitted to XLEN.
    logic [CNTW+15:0] cnt_ext;
    logic [15:0]      cnt16;
    logic [XLEN+31:0] marker_ext;
    logic [XLEN-1:0]  marker_word;
    assign cnt_ext     = {16'h0000, dropped_q};
    assign cnt16       = cnt_ext[15:0];
    assign marker_ext  = {{XLEN{1'b0}}, 16'hDEAD, cnt16};
    assign marker_word = marker_ext[XLEN-1:0];
`endif

    // Push/pop/drop decisions; flush overrides all of them.
    always_comb begin
        full        = (count_q == FW'(DEPTH));
        not_empty   = (count_q != '0);
        pop         = not_empty && udma_ready_i && !flush_i;
        trace_req   = word_valid_i && enable_i && !flush_i;
`ifdef TRDB_OVERFLOW_MARKER_EN
        // Trace words wait until the marker has gone in, so only NORMAL accepts them.
        marker_push   = (state_q == MARKER) && (!full || pop) && !flush_i;
        trace_allowed = (state_q == NORMAL);
        push_data     = marker_push ? marker_word : word_i;
`else
        marker_push   = 1'b0;
        trace_allowed = 1'b1;
        push_data     = word_i;
`endif
        trace_push  = trace_req && trace_allowed && (!full || pop);
        push        = trace_push || marker_push;
        drop        = trace_req && !trace_push;
        count_d     = count_q + FW'(push) - FW'(pop);
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointers, fill level, overflow status and watermark pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            prev_count_q <= '0;
            overflow_q   <= 1'b0;
            dropped_q    <= '0;
            irq_q        <= 1'b0;
        end else if (flush_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            prev_count_q <= '0;
            overflow_q   <= 1'b0;
            dropped_q    <= '0;
            irq_q        <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q      <= count_d;
            prev_count_q <= count_q;
            if (drop) begin
                overflow_q <= 1'b1;
                if (dropped_q != {CNTW{1'b1}}) begin
                    dropped_q <= dropped_q + CNTW'(1);
                end
            end
            // Rising crossing of the watermark seen on the visible fill level.
            irq_q <= (threshold_i != '0) && (prev_count_q < threshold_i)
                     && (count_q >= threshold_i);
        end
    end

    // Overflow episode tracking: NORMAL -> DROPPING -> MARKER -> NORMAL.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= NORMAL;
        end else if (flush_i) begin
            state_q <= NORMAL;
        end else begin
            case (state_q)
                NORMAL: begin
                    if (drop) begin
                        state_q <= DROPPING;
                    end
                end
                DROPPING: begin
                    if (!full) begin
                        state_q <= MARKER;
                    end
                end
                MARKER: begin
`ifdef TRDB_OVERFLOW_MARKER_EN
                    if (marker_push) begin
                        state_q <= NORMAL;
                    end
`else
                    state_q <= NORMAL;
`endif
                end
                default: state_q <= NORMAL;
            endcase
        end
    end

    assign udma_valid_o    = not_empty;
    assign udma_data_o     = not_empty ? mem_q[rd_ptr_q] : '0;
    assign fill_level_o    = count_q;
    assign overflow_o      = overflow_q;
    assign dropped_cnt_o   = dropped_q;
    assign threshold_irq_o = irq_q;

endmodule
